// File: rtl/operand_forward_ctrl.sv
// Forwarding and load-use hazard control for the 32x16 register bank operand muxes.
// Keeps a 3-deep shadow of EX/DM/WB destinations and registers the EX-stage operand selects.
module operand_forward_ctrl #(
   parameter bit          ZERO_REG_HW = 1'b1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_ra,
   input  logic [4:0]       id_rb,
   input  logic             id_use_a,
   input  logic             id_use_b,
   input  logic             id_imm,
   input  logic [4:0]       id_rw,
   input  logic             id_we,
   input  logic             id_load,
   input  logic             flush,
   output logic [1:0]       mux_sel_A,
   output logic [1:0]       mux_sel_B,
   output logic             imm_sel,
   output logic [4:0]       rw_dm,
   output logic             rf_we,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rw;
      logic       we;
      logic       load;
   } stage_t;

   localparam logic [1:0] SelBank = 2'b00;
   localparam logic [1:0] SelEx   = 2'b01;
   localparam logic [1:0] SelDm   = 2'b10;
   localparam logic [1:0] SelWb   = 2'b11;

   stage_t           ex_q, dm_q, wb_q;
   stage_t           ex_d;
   logic [1:0]       sel_a_q, sel_a_d;
   logic [1:0]       sel_b_q, sel_b_d;
   logic             imm_q, imm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             issue;
   logic             use_b_reg;
   logic             hazard_a, hazard_b;

   function automatic logic match(input stage_t s, input logic [4:0] r);
      return s.valid & s.we & (s.rw == r) & ~(ZERO_REG_HW & (r == 5'd0));
   endfunction

   // Nearest producer wins: EX before DM before WB.
   function automatic logic [1:0] fwd_sel(input logic       use_src,
                                          input logic [4:0] r,
                                          input stage_t     ex,
                                          input stage_t     dm,
                                          input stage_t     wb);
      logic [1:0] sel;
      sel = SelBank;
      if (use_src) begin
         if (match(ex, r)) begin
            sel = SelEx;
         end else if (match(dm, r)) begin
            sel = SelDm;
         end else if (match(wb, r)) begin
            sel = SelWb;
         end
      end
      return sel;
   endfunction

   // Operand B is the immediate, so the register source cannot create a hazard.
   assign use_b_reg = id_use_b & ~id_imm;

   always_comb begin
      hazard_a = id_use_a & match(ex_q, id_ra);
      hazard_b = use_b_reg & match(ex_q, id_rb);
      stall    = id_valid & ~flush & ex_q.load & (hazard_a | hazard_b);
   end

   assign issue = id_valid & ~stall & ~flush;

   always_comb begin
      ex_d    = '0;
      sel_a_d = SelBank;
      sel_b_d = SelBank;
      imm_d   = 1'b0;
      if (issue) begin
         ex_d.valid = 1'b1;
         ex_d.rw    = id_rw;
         ex_d.we    = id_we;
         ex_d.load  = id_load;
         sel_a_d    = fwd_sel(id_use_a, id_ra, ex_q, dm_q, wb_q);
         sel_b_d    = fwd_sel(use_b_reg, id_rb, ex_q, dm_q, wb_q);
         imm_d      = id_imm;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q    <= '0;
         dm_q    <= '0;
         wb_q    <= '0;
         sel_a_q <= SelBank;
         sel_b_q <= SelBank;
         imm_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         dm_q    <= ex_q;
         wb_q    <= dm_q;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         imm_q   <= imm_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mux_sel_A   = sel_a_q;
   assign mux_sel_B   = sel_b_q;
   assign imm_sel     = imm_q;
   assign rw_dm       = dm_q.rw;
   assign rf_we       = dm_q.valid & dm_q.we;
   assign stall_count = cnt_q;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Randomized and directed bench for operand_forward_ctrl; a queue-based pipeline model feeds
// a scoreboard, and a narrow-counter instance exercises stall_count saturation.
module tb_operand_forward_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_ra = '0, id_rb = '0, id_rw = '0;
   logic       id_use_a = 1'b0, id_use_b = 1'b0, id_imm = 1'b0;
   logic       id_we = 1'b0, id_load = 1'b0, flush = 1'b0;

   logic [1:0]  sel_a, sel_b, sel_a4, sel_b4;
   logic        imm_sel, imm_sel4, rf_we, rf_we4, stall, stall4;
   logic [4:0]  rw_dm, rw_dm4;
   logic [15:0] cnt16;
   logic [3:0]  cnt4;

   always #5 clk = ~clk;

   operand_forward_ctrl dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
      .id_use_a(id_use_a), .id_use_b(id_use_b), .id_imm(id_imm), .id_rw(id_rw),
      .id_we(id_we), .id_load(id_load), .flush(flush), .mux_sel_A(sel_a),
      .mux_sel_B(sel_b), .imm_sel(imm_sel), .rw_dm(rw_dm), .rf_we(rf_we),
      .stall(stall), .stall_count(cnt16)
   );

   operand_forward_ctrl #(.ZERO_REG_HW(1'b1), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
      .id_use_a(id_use_a), .id_use_b(id_use_b), .id_imm(id_imm), .id_rw(id_rw),
      .id_we(id_we), .id_load(id_load), .flush(flush), .mux_sel_A(sel_a4),
      .mux_sel_B(sel_b4), .imm_sel(imm_sel4), .rw_dm(rw_dm4), .rf_we(rf_we4),
      .stall(stall4), .stall_count(cnt4)
   );

   typedef struct {
      bit valid;
      int rw;
      bit we;
      bit load;
   } instr_t;

   typedef struct {
      bit [1:0]    sa, sb;
      bit          imm, stl, we;
      bit [4:0]    rwd;
      bit [15:0]   c16;
      bit [3:0]    c4;
   } exp_t;

   instr_t      hist[$];   // [0]=EX, [1]=DM, [2]=WB
   exp_t        sbq[$];
   bit [1:0]    m_sel_a, m_sel_b;
   bit          m_imm, m_stall, known;
   longint      n_stall;
   int          n_cmp = 0, n_bad = 0;

   // Distance (1..3) to the nearest in-flight writer of r, or 0 if none.
   function automatic int producer(int r);
      for (int d = 0; d < 3; d++) begin
         if (hist[d].valid && hist[d].we && hist[d].rw == r && r != 0) return d + 1;
      end
      return 0;
   endfunction

   function automatic longint sat(longint n, int w);
      longint mx = (longint'(1) << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic step(input bit r, input bit v, input int ra, input int rb, input bit ua,
                       input bit ub, input bit im, input int rw, input bit we, input bit ld,
                       input bit fl);
      instr_t nw;
      exp_t   e;
      bit     iss;
      @(posedge clk);
      #1;
      rst = r; id_valid = v; id_ra = 5'(ra); id_rb = 5'(rb); id_use_a = ua; id_use_b = ub;
      id_imm = im; id_rw = 5'(rw); id_we = we; id_load = ld; flush = fl;
      m_stall = v && !fl && hist[0].load &&
                ((ua && producer(ra) == 1) || (ub && !im && producer(rb) == 1));
      if (known) begin
         e.sa  = m_sel_a;
         e.sb  = m_sel_b;
         e.imm = m_imm;
         e.stl = m_stall;
         e.we  = hist[1].valid && hist[1].we;
         e.rwd = hist[1].valid ? 5'(hist[1].rw) : 5'd0;
         e.c16 = 16'(sat(n_stall, 16));
         e.c4  = 4'(sat(n_stall, 4));
         sbq.push_back(e);
      end
      if (r) begin
         hist = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
         m_sel_a = 0; m_sel_b = 0; m_imm = 0; n_stall = 0; known = 1;
      end else if (known) begin
         if (m_stall) n_stall++;
         iss = v && !m_stall && !fl;
         nw = iss ? '{1, rw, we, ld} : '{0, 0, 0, 0};
         m_sel_a = (iss && ua) ? 2'(producer(ra)) : 2'd0;
         m_sel_b = (iss && ub && !im) ? 2'(producer(rb)) : 2'd0;
         m_imm = iss && im;
         hist.push_front(nw);
         void'(hist.pop_back());
      end
   endtask

   task automatic nop();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Issue one instruction, re-presenting it while the model says ID is stalled.
   task automatic issue(input int ra, input int rb, input bit ua, input bit ub, input bit im,
                        input int rw, input bit we, input bit ld, input bit fl);
      int tries = 0;
      do begin
         step(0, 1, ra, rb, ua, ub, im, rw, we, ld, fl);
         tries++;
      end while (m_stall && tries < 4);
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         cmp("mux_sel_A", 32'(sel_a), 32'(e.sa));
         cmp("mux_sel_B", 32'(sel_b), 32'(e.sb));
         cmp("imm_sel", 32'(imm_sel), 32'(e.imm));
         cmp("stall", 32'(stall), 32'(e.stl));
         cmp("rf_we", 32'(rf_we), 32'(e.we));
         cmp("rw_dm", 32'(rw_dm), 32'(e.rwd));
         cmp("stall_count", 32'(cnt16), 32'(e.c16));
         cmp("w4_mux_sel_A", 32'(sel_a4), 32'(e.sa));
         cmp("w4_mux_sel_B", 32'(sel_b4), 32'(e.sb));
         cmp("w4_imm_sel", 32'(imm_sel4), 32'(e.imm));
         cmp("w4_stall", 32'(stall4), 32'(e.stl));
         cmp("w4_rf_we", 32'(rf_we4), 32'(e.we));
         cmp("w4_rw_dm", 32'(rw_dm4), 32'(e.rwd));
         cmp("w4_stall_count_sat", 32'(cnt4), 32'(e.c4));
      end
   end

   initial begin
      hist = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
      known = 0; n_stall = 0;
      // Reset held two cycles with random ID inputs.
      repeat (2) step(1, 1, $urandom_range(0, 31), $urandom_range(0, 31), 1, 1, 0,
                      $urandom_range(0, 31), 1, 1, 0);
      // Back-to-back ALU forwarding at distances 1, 2, 3.
      issue(0, 0, 0, 0, 0, 3, 1, 0, 0);
      issue(3, 0, 1, 0, 0, 9, 1, 0, 0);
      nop(); nop(); nop();
      issue(0, 0, 0, 0, 0, 3, 1, 0, 0);
      nop();
      issue(3, 0, 1, 0, 0, 9, 1, 0, 0);
      nop(); nop(); nop();
      issue(0, 0, 0, 0, 0, 3, 1, 0, 0);
      nop(); nop();
      issue(3, 0, 1, 0, 0, 9, 1, 0, 0);
      nop(); nop(); nop();
      // Load-use stall, then immediate masking the same hazard.
      issue(0, 0, 0, 0, 0, 5, 1, 1, 0);
      issue(0, 5, 0, 1, 0, 6, 1, 0, 0);
      nop(); nop(); nop();
      issue(0, 0, 0, 0, 0, 5, 1, 1, 0);
      issue(0, 5, 0, 1, 1, 6, 1, 0, 0);
      nop(); nop(); nop();
      // Zero register, then EX/WB priority for r7.
      issue(0, 0, 0, 0, 0, 0, 1, 0, 0);
      issue(0, 0, 1, 1, 0, 8, 1, 0, 0);
      nop(); nop(); nop();
      issue(0, 0, 0, 0, 0, 7, 1, 0, 0);
      nop();
      issue(0, 0, 0, 0, 0, 7, 1, 0, 0);
      issue(7, 7, 1, 1, 0, 8, 1, 0, 0);
      nop(); nop(); nop();
      // Flush overrides a load-use stall.
      issue(0, 0, 0, 0, 0, 2, 1, 1, 0);
      step(0, 1, 2, 0, 1, 0, 0, 4, 1, 0, 1);
      nop(); nop(); nop();
      // Dense load-use chain to push the narrow counter past saturation.
      for (int i = 0; i < 24; i++) issue(5, 0, 1, 0, 0, 5, 1, 1, 0);
      nop(); nop();
      // Random traffic over a small register window so hazards are frequent.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) != 0),
              $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      end
      @(negedge clk);
      @(negedge clk);
      if (sbq.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
